// File: rtl/vjtag_debug_host.sv
// vjtag_debug_host: on-chip virtual-JTAG master for the Nios II debug slave.
// One command runs a full IR-update / DR-capture-shift-update transaction.
module vjtag_debug_host #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int PW = $clog2(TCK_DIV);
  localparam int CW = $clog2(DR_WIDTH + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(TCK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PW-1:0]       r_phase;
  logic                r_tck;
  logic                r_tdi;
  logic                r_busy;
  logic                r_rsp_valid;
  logic [CW-1:0]       r_cnt;
  logic [IR_WIDTH-1:0] r_ir;
  logic [IR_WIDTH-1:0] r_ir_in;
  logic [DR_WIDTH-1:0] r_tx;
  logic [DR_WIDTH-1:0] r_rx;
  logic [DR_WIDTH-1:0] r_rsp_dr;
  logic [DR_WIDTH-1:0] w_tx_sh;
  logic [DR_WIDTH:0]   w_rx_cat;
  logic                w_edge;
  logic                w_rise;
  logic                w_fall;
  logic                w_accept;
  logic                w_sdr_done;
  logic                w_unused;

  assign w_edge     = (r_phase == PH_LAST);
  assign w_rise     = w_edge & ~r_tck;
  assign w_fall     = w_edge & r_tck;
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_sdr_done = (r_cnt == CNT_LAST);
  assign w_tx_sh    = r_tx >> 1;
  assign w_rx_cat   = {vji_tdo, r_rx};
  assign w_unused   = ^{vji_ir_out, w_rx_cat[0]};

  // busy covers the gap between acceptance and the first tck_fall
  assign cmd_ready = (r_state == S_IDLE) & ~r_busy & ~r_rsp_valid;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dr    = r_rsp_dr;
  assign vji_tck   = r_tck;
  assign vji_tdi   = r_tdi;
  assign vji_ir_in = r_ir_in;
  assign vji_rti   = (r_state == S_IDLE);
  assign vji_uir   = (r_state == S_UIR);
  assign vji_cdr   = (r_state == S_CDR);
  assign vji_sdr   = (r_state == S_SDR);
  assign vji_udr   = (r_state == S_UDR);

  always_comb begin
    w_next = r_state;
    if (w_fall) begin
      case (r_state)
        S_IDLE:  if (r_busy) w_next = S_UIR;
        S_UIR:   w_next = S_CDR;
        S_CDR:   w_next = S_SDR;
        S_SDR:   if (w_sdr_done) w_next = S_UDR;
        S_UDR:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= '0;
      r_tck   <= 1'b0;
      r_state <= S_IDLE;
    end else begin
      r_phase <= w_edge ? '0 : r_phase + PW'(1);
      if (w_edge) r_tck <= ~r_tck;
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tdi       <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_cnt       <= '0;
      r_ir        <= '0;
      r_ir_in     <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_rsp_dr    <= '0;
    end else begin
      if (w_accept) begin
        r_busy <= 1'b1;
        r_ir   <= cmd_ir;
        r_tx   <= cmd_dr;
      end
      if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
      // TDO is taken from the value present before the rising edge
      if (w_rise && r_state == S_SDR) begin
        r_rx  <= w_rx_cat[DR_WIDTH:1];
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_fall) begin
        case (r_state)
          S_IDLE: if (r_busy) r_ir_in <= r_ir;
          S_CDR: begin
            r_tdi <= r_tx[0];
            r_cnt <= '0;
          end
          S_SDR: begin
            if (w_sdr_done) begin
              r_tdi <= 1'b0;
            end else begin
              r_tx  <= w_tx_sh;
              r_tdi <= w_tx_sh[0];
            end
          end
          S_UDR: begin
            r_rsp_dr    <= r_rx;
            r_rsp_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vjtag_debug_host.sv
// tb_vjtag_debug_host: directed and random transactions against loopback slaves.
// Expected data follows the scan-chain exchange: response = old slave, slave = command.
`timescale 1ns/1ps
module tb_vjtag_debug_host;

  localparam int DRW = 38;
  localparam int DIV = 4;
  localparam logic [4:0] C_IDLE = 5'b00001;
  localparam logic [4:0] C_UIR  = 5'b10000;
  localparam logic [4:0] C_CDR  = 5'b01000;
  localparam logic [4:0] C_SDR  = 5'b00100;
  localparam logic [4:0] C_UDR  = 5'b00010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- DUT A: default geometry ----------------
  logic a_rst = 1'b1, a_cv = 1'b0, a_rr = 1'b0;
  logic a_cr, a_rv, a_tck, a_tdi, a_tdo;
  logic a_uir, a_cdr, a_sdr, a_udr, a_rti;
  logic [1:0] a_ir = '0;
  logic [1:0] a_ir_in, a_ir_out;
  logic [DRW-1:0] a_dr = '0;
  logic [DRW-1:0] a_rsp;
  assign a_ir_out = 2'b00;

  vjtag_debug_host #(.IR_WIDTH(2), .DR_WIDTH(DRW), .TCK_DIV(DIV)) u_a (
    .clk(clk), .reset(a_rst),
    .cmd_valid(a_cv), .cmd_ready(a_cr), .cmd_ir(a_ir), .cmd_dr(a_dr),
    .rsp_valid(a_rv), .rsp_ready(a_rr), .rsp_dr(a_rsp),
    .vji_tck(a_tck), .vji_tdi(a_tdi), .vji_tdo(a_tdo),
    .vji_ir_in(a_ir_in), .vji_ir_out(a_ir_out),
    .vji_uir(a_uir), .vji_cdr(a_cdr), .vji_sdr(a_sdr),
    .vji_udr(a_udr), .vji_rti(a_rti));

  logic [DRW-1:0] sa_sr, sa_udr;
  logic [DRW-1:0] sa_pre = '0;
  logic sa_load = 1'b0, sa_ptck = 1'b0;
  logic sa_rise;
  logic [4:0] la_code [0:4095];
  logic [1:0] la_ir [0:4095];
  int la_n = 0;

  assign a_tdo   = sa_sr[0];
  assign sa_rise = a_tck & ~sa_ptck;

  always @(posedge clk) begin
    sa_ptck <= a_tck;
    if (sa_load) sa_sr <= sa_pre;
    else if (sa_rise && a_sdr) sa_sr <= {a_tdi, sa_sr[DRW-1:1]};
    if (sa_rise && a_udr) sa_udr <= sa_sr;
    if (sa_rise && la_n < 4096) begin
      la_code[la_n] <= {a_uir, a_cdr, a_sdr, a_udr, a_rti};
      la_ir[la_n]   <= a_ir_in;
      la_n          <= la_n + 1;
    end
  end

  // ---------------- DUT B: TCK_DIV=2, DR_WIDTH=1 ----------------
  logic b_rst = 1'b1, b_cv = 1'b0, b_rr = 1'b0;
  logic b_cr, b_rv, b_tck, b_tdi, b_tdo;
  logic b_uir, b_cdr, b_sdr, b_udr, b_rti;
  logic [1:0] b_ir = 2'b01;
  logic [1:0] b_ir_in, b_ir_out;
  logic [0:0] b_dr = '0;
  logic [0:0] b_rsp;
  assign b_ir_out = 2'b00;

  vjtag_debug_host #(.IR_WIDTH(2), .DR_WIDTH(1), .TCK_DIV(2)) u_b (
    .clk(clk), .reset(b_rst),
    .cmd_valid(b_cv), .cmd_ready(b_cr), .cmd_ir(b_ir), .cmd_dr(b_dr),
    .rsp_valid(b_rv), .rsp_ready(b_rr), .rsp_dr(b_rsp),
    .vji_tck(b_tck), .vji_tdi(b_tdi), .vji_tdo(b_tdo),
    .vji_ir_in(b_ir_in), .vji_ir_out(b_ir_out),
    .vji_uir(b_uir), .vji_cdr(b_cdr), .vji_sdr(b_sdr),
    .vji_udr(b_udr), .vji_rti(b_rti));

  logic sb_sr, sb_udr;
  logic sb_pre = 1'b0, sb_load = 1'b0, sb_ptck = 1'b0;
  logic sb_rise;
  int sb_nsdr = 0;
  assign b_tdo   = sb_sr;
  assign sb_rise = b_tck & ~sb_ptck;

  always @(posedge clk) begin
    sb_ptck <= b_tck;
    if (sb_load) sb_sr <= sb_pre;
    else if (sb_rise && b_sdr) sb_sr <= b_tdi;
    if (sb_rise && b_udr) sb_udr <= sb_sr;
    if (sb_rise && b_sdr) sb_nsdr <= sb_nsdr + 1;
  end

  // ---------------- reference model state ----------------
  logic [DRW-1:0] m_slave = '0;
  logic [DRW-1:0] ex_dr = '0;
  logic [1:0] ex_ir = '0;
  int a_s = 0;

  task automatic load_a(input logic [DRW-1:0] pre);
    sa_pre = pre;
    sa_load = 1'b1;
    @(negedge clk);
    sa_load = 1'b0;
    m_slave = pre;
  endtask

  task automatic issue_a(input logic [1:0] ir, input logic [DRW-1:0] dr);
    int w;
    w = 0;
    while (!a_cr && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("issue ready", 64'(a_cr), 64'(1));
    ex_ir = ir;
    ex_dr = dr;
    a_s = la_n;
    a_ir = ir;
    a_dr = dr;
    a_cv = 1'b1;
    @(negedge clk);
    a_cv = 1'b0;
    a_ir = ~ir;
    a_dr = ~dr;
    chk("accept drops ready", 64'(a_cr), 64'(0));
  endtask

  task automatic finish_a(input string tag);
    int w, t0, t1, nsdr, bad;
    int q[$];
    logic [4:0] e;
    logic [1:0] irv;
    w = 0; t0 = -1; nsdr = 0; bad = 0; irv = '0;
    while (!a_rv && w < 2000) begin
      if (a_uir && t0 < 0) t0 = cyc;
      @(negedge clk);
      w++;
    end
    t1 = cyc;
    chk({tag, " rsp_valid"}, 64'(a_rv), 64'(1));
    chk({tag, " latency"}, 64'(t1 - t0), 64'((DRW + 3) * 2 * DIV));
    chk({tag, " rsp_dr"}, 64'(a_rsp), 64'(m_slave));
    chk({tag, " slave sr"}, 64'(sa_udr), 64'(ex_dr));
    for (int i = a_s; i < la_n; i++)
      if (la_code[i] != C_IDLE) q.push_back(i);
    chk({tag, " periods"}, 64'(q.size()), 64'(DRW + 3));
    for (int k = 0; k < q.size(); k++) begin
      if (k == 0) e = C_UIR;
      else if (k == 1) e = C_CDR;
      else if (k == q.size() - 1) e = C_UDR;
      else e = C_SDR;
      if (la_code[q[k]] != e) bad++;
      if (la_code[q[k]] == C_SDR) nsdr++;
    end
    chk({tag, " strobe order"}, 64'(bad), 64'(0));
    chk({tag, " sdr periods"}, 64'(nsdr), 64'(DRW));
    if (q.size() > 0) irv = la_ir[q[0]];
    chk({tag, " ir_in"}, 64'(irv), 64'(ex_ir));
    m_slave = ex_dr;
  endtask

  task automatic take_a(input string tag);
    a_rr = 1'b1;
    @(negedge clk);
    a_rr = 1'b0;
    chk({tag, " rsp cleared"}, 64'(a_rv), 64'(0));
    chk({tag, " ready back"}, 64'(a_cr), 64'(1));
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, " tck"}, 64'(a_tck), 64'(0));
    chk({tag, " tdi"}, 64'(a_tdi), 64'(0));
    chk({tag, " ir_in"}, 64'(a_ir_in), 64'(0));
    chk({tag, " strobes"}, 64'({a_uir, a_cdr, a_sdr, a_udr, a_rti}),
        64'(C_IDLE));
    chk({tag, " rsp_valid"}, 64'(a_rv), 64'(0));
    chk({tag, " rsp_dr"}, 64'(a_rsp), 64'(0));
    chk({tag, " cmd_ready"}, 64'(a_cr), 64'(1));
  endtask

  task automatic txn_b(input string tag, input logic pre, input logic dr);
    int w, t0, t1, n0;
    sb_pre = pre;
    sb_load = 1'b1;
    @(negedge clk);
    sb_load = 1'b0;
    w = 0;
    while (!b_cr && w < 100) begin
      @(negedge clk);
      w++;
    end
    n0 = sb_nsdr;
    b_dr = dr;
    b_cv = 1'b1;
    @(negedge clk);
    b_cv = 1'b0;
    w = 0; t0 = -1;
    while (!b_rv && w < 200) begin
      if (b_uir && t0 < 0) t0 = cyc;
      @(negedge clk);
      w++;
    end
    t1 = cyc;
    chk({tag, " rsp_valid"}, 64'(b_rv), 64'(1));
    chk({tag, " latency"}, 64'(t1 - t0), 64'(16));
    chk({tag, " rsp_dr"}, 64'(b_rsp), 64'(pre));
    chk({tag, " slave bit"}, 64'(sb_udr), 64'(dr));
    chk({tag, " sdr periods"}, 64'(sb_nsdr - n0), 64'(1));
    b_rr = 1'b1;
    @(negedge clk);
    b_rr = 1'b0;
    chk({tag, " rsp cleared"}, 64'(b_rv), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r64;
    logic [DRW-1:0] rdr, hold_dr;
    logic [1:0] rir;
    logic prev;
    int bad, r1, r2, r3, w, n;

    repeat (4) @(negedge clk);
    check_reset_a("reset");
    a_rst = 1'b0;

    // idle: TCK period and quiet strobes
    bad = 0; r1 = -1; r2 = -1; r3 = -1; prev = a_tck;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_tck && !prev) begin
        if (r1 < 0) r1 = cyc;
        else if (r2 < 0) r2 = cyc;
        else if (r3 < 0) r3 = cyc;
      end
      prev = a_tck;
      if ({a_uir, a_cdr, a_sdr, a_udr, a_rti} != C_IDLE || !a_cr || a_rv)
        bad++;
    end
    chk("idle tck period 1", 64'(r2 - r1), 64'(2 * DIV));
    chk("idle tck period 2", 64'(r3 - r2), 64'(2 * DIV));
    chk("idle quiet", 64'(bad), 64'(0));

    // directed loopback
    load_a(38'h15_AAAA_AAAA);
    issue_a(2'b01, 38'h2A_5555_5555);
    finish_a("t1");

    // response held off; a waiting command must not be taken
    hold_dr = a_rsp;
    bad = 0;
    a_ir = 2'b10;
    a_dr = '1;
    a_cv = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!a_rv || a_rsp !== hold_dr || a_cr || a_uir) bad++;
    end
    chk("hold stable", 64'(bad), 64'(0));
    a_rr = 1'b1;
    @(negedge clk);
    a_rr = 1'b0;
    a_cv = 1'b0;
    chk("hold rsp cleared", 64'(a_rv), 64'(0));
    chk("same-cycle cmd refused", 64'(a_cr), 64'(1));

    // back-to-back through the same slave contents
    issue_a(2'b10, '1);
    finish_a("t2");
    take_a("t2");
    issue_a(2'b11, '0);
    finish_a("t3");
    take_a("t3");

    // random transactions
    for (int i = 0; i < 3; i++) begin
      r64 = {$urandom, $urandom};
      load_a(r64[DRW-1:0]);
      r64 = {$urandom, $urandom};
      rdr = r64[DRW-1:0];
      rir = 2'($urandom_range(0, 3));
      issue_a(rir, rdr);
      finish_a($sformatf("rnd%0d", i));
      take_a($sformatf("rnd%0d", i));
    end

    // abort in the middle of the shift
    load_a(38'h00_1234_5678);
    issue_a(2'b01, 38'h3F_0F0F_0F0F);
    w = 0; n = 0;
    while (n < 17 && w < 1000) begin
      @(negedge clk);
      w++;
      n = 0;
      for (int i = a_s; i < la_n; i++) if (la_code[i] == C_SDR) n++;
    end
    chk("abort reached bit 17", 64'(n), 64'(17));
    a_rst = 1'b1;
    @(negedge clk);
    check_reset_a("abort");
    a_rst = 1'b0;
    n = la_n;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (a_rv || a_udr) bad++;
    end
    chk("abort no response", 64'(bad), 64'(0));
    load_a(38'h2B_CDEF_0123);
    issue_a(2'b10, 38'h14_3210_FEDC);
    finish_a("post-abort");
    take_a("post-abort");

    // minimal geometry
    b_rst = 1'b0;
    @(negedge clk);
    txn_b("b1", 1'b1, 1'b0);
    txn_b("b2", 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vjtag_debug_host.md
Name: vjtag_debug_host

Overview:
- Host-side driver for the Nios II debug slave's virtual-JTAG interface.
- Generates the TCK, TDI, IR and virtual-state strobes (UIR/CDR/SDR/UDR/RTI) that the debug slave consumes, and captures its TDO.
- Lets an on-chip agent (bring-up sequencer or test harness) issue debug commands without a physical JTAG cable.
- Takes a command (IR plus DR word), runs one full IR-update / DR-capture-shift-update transaction, and returns the shifted-out DR word.

Parameters:
- IR_WIDTH, 2, width of the virtual IR.
- DR_WIDTH, 38, length of the DR shift chain in bits.
- TCK_DIV, 4, clk cycles per TCK half-period; legal range is 2 or greater.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_ir  in  IR_WIDTH  IR value for this transaction.
- cmd_dr  in  DR_WIDTH  DR data to shift in, LSB first.
- rsp_valid  out  1  captured DR word is available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_dr  out  DR_WIDTH  captured TDO bits; bit 0 is the first bit shifted out.
- vji_tck  out  1  generated TCK.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_WIDTH  IR presented to the slave.
- vji_ir_out  in  IR_WIDTH  slave IR status; unused, reserved.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state indicators.

Behaviour:
- One clock (clk); reset is synchronous and active-high.

TCK generation:
- Phase counter runs 0..TCK_DIV-1 continuously; vji_tck toggles when the counter reaches TCK_DIV-1.
- tck_rise is the clk cycle in which vji_tck goes 0->1; tck_fall is the cycle in which it goes 1->0.
- Every vji_* output changes only on tck_fall, except vji_tck itself and the IDLE-entry case below.
- vji_tdo is sampled on the tck_rise cycle, i.e. the value present before the rising edge.

Reset values:
- vji_tck=0, phase counter=0, vji_tdi=0, vji_ir_in=0.
- vji_uir=vji_cdr=vji_sdr=vji_udr=0, vji_rti=1.
- rsp_valid=0, rsp_dr=0, cmd_ready=1, FSM=IDLE.
- Reset asserted mid-transaction aborts immediately to these values, with no partial response and no UDR strobe.

FSM (transitions only on tck_fall; strobes are one-hot and mutually exclusive):
- IDLE: rti=1. cmd_ready=1 while no response is pending.
  - cmd_valid&&cmd_ready latches cmd_ir/cmd_dr into tx registers and drops cmd_ready the next cycle.
  - On the next tck_fall after acceptance -> UIR.
- UIR (1 TCK period): uir=1, vji_ir_in=latched IR (held until the next accepted command) -> CDR.
- CDR (1 period): cdr=1 -> SDR; on that same tck_fall, vji_tdi=tx[0].
- SDR (DR_WIDTH periods):
  - sdr=1.
  - Each tck_rise: rx <= {vji_tdo, rx[DR_WIDTH-1:1]}; bit counter increments.
  - Each tck_fall: tx shifts right and vji_tdi=next tx bit.
  - After the DR_WIDTH-th rise, the next tck_fall -> UDR.
- UDR (1 period): udr=1, vji_tdi=0 -> IDLE.
  - On entry to IDLE: rsp_dr<=rx and rsp_valid<=1 in the same clk cycle.

Response handshake:
- rsp_valid holds until rsp_valid&&rsp_ready; rsp_dr is stable while valid.
- cmd_ready=0 from acceptance until the response handshake completes. Acceptance and response therefore never overlap.
- A command presented in the same cycle as the rsp handshake is not accepted that cycle.

Latency:
- Transaction length is (3+DR_WIDTH) TCK periods from the first tck_fall after acceptance to IDLE entry.
- Acceptance to that first tck_fall is 1..2*TCK_DIV clk cycles.

Width rules:
- Bit counter width is clog2(DR_WIDTH+1).
- No truncation; DR_WIDTH=1 is legal (SDR lasts one period).

Test Plan:
- Reset, then idle 20 clks with TCK_DIV=4 -> vji_tck period is 8 clks, rti=1, all other strobes 0, cmd_ready=1, rsp_valid=0.
- cmd_ir=2'b01, cmd_dr=38'h2A_5555_5555, with a loopback slave model (38-bit sr shifting in tdi at MSB, tdo=sr[0], preloaded with 38'h15_AAAA_AAAA):
  - rsp_dr=38'h15_AAAA_AAAA.
  - Slave sr equals 38'h2A_5555_5555 at UDR.
  - Exactly 38 sdr TCK periods; strobe order uir, cdr, sdr, udr; vji_ir_in=2'b01 during UIR.
- rsp_ready held 0 for 50 clks after rsp_valid -> rsp_valid and rsp_dr stable; cmd_valid=1 during that window is not accepted (cmd_ready=0). Release rsp_ready -> command accepted afterwards.
- Two back-to-back commands (IR 2'b10 then 2'b11, DR all-ones then zero) -> slave sr after the second transaction=0 and rsp_dr of the second=all-ones.
- Assert reset at SDR bit 17 -> next cycle all outputs equal reset values, no rsp_valid. A following command completes normally with correct data.
- TCK_DIV=2, DR_WIDTH=1 -> the transaction spans 4 TCK periods (16 clks after the first tck_fall); a single bit round-trips.
